// File: rtl/gbt_link_sequencer.sv
// rtl/gbt_link_sequencer.sv - GBT optical link bring-up and recovery sequencer
// Walks SFP enable, GBT resets and ready checks, retrying on failure until FAULT.
package ckrs_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

module gbt_link_sequencer #(
  parameter int SFP_SETTLE_CYCLES = 4000,
  parameter int MGT_RESET_CYCLES  = 16,
  parameter int TX_TIMEOUT_CYCLES = 400000,
  parameter int RX_TIMEOUT_CYCLES = 400000,
  parameter int STABLE_CYCLES     = 4000,
  parameter int MAX_RETRIES       = 7,
  parameter int CNT_W             = 16
) (
  input  ckrs_pkg::ckrs_t   ClkRs_ix,
  input  logic              enable_i,
  input  logic              force_relink_i,
  input  logic              pll_locked_i,
  input  logic              sfp_los_i,
  input  logic              gbttx_ready_i,
  input  logic              gbtrx_ready_i,
  input  logic              rx_errordetected_i,
  output logic              sfp_txdisable_o,
  output logic              gbt_general_reset_o,
  output logic              gbt_manual_reset_tx_o,
  output logic              gbt_manual_reset_rx_o,
  output logic              link_up_o,
  output logic              fault_o,
  output logic [3:0]        state_o,
  output logic [3:0]        retry_cnt_o,
  output logic [CNT_W-1:0]  link_loss_cnt_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SFP_ON    = 4'd1,
    S_GEN_RESET = 4'd2,
    S_WAIT_TX   = 4'd3,
    S_WAIT_RX   = 4'd4,
    S_RX_RESET  = 4'd5,
    S_STABLE    = 4'd6,
    S_UP        = 4'd7,
    S_FAULT     = 4'd8
  } state_t;

  localparam int T_A  = (SFP_SETTLE_CYCLES > MGT_RESET_CYCLES) ? SFP_SETTLE_CYCLES : MGT_RESET_CYCLES;
  localparam int T_B  = (TX_TIMEOUT_CYCLES > RX_TIMEOUT_CYCLES) ? TX_TIMEOUT_CYCLES : RX_TIMEOUT_CYCLES;
  localparam int T_C  = (T_A > T_B) ? T_A : T_B;
  localparam int TMAX = (T_C > STABLE_CYCLES) ? T_C : STABLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  // Timer holds (cycles spent in state - 1), so the T-th cycle is timer == T-1.
  localparam logic [TW-1:0] T_SFP_END = TW'(SFP_SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_MGT_END = TW'(MGT_RESET_CYCLES - 1);
  localparam logic [TW-1:0] T_TX_END  = TW'(TX_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_RX_END  = TW'(RX_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_STB_END = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_SAT     = TW'(TMAX);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  state_t             r_state;
  logic [TW-1:0]      r_timer;
  logic [3:0]         r_retry;
  logic [CNT_W-1:0]   r_loss;
  logic               r_txdisable;
  logic               r_gen_reset;
  logic               r_man_tx;
  logic               r_man_rx;
  logic               r_link_up;
  logic               r_fault;

  state_t             w_next;
  state_t             w_fail_target;
  logic               w_fail;
  logic               w_restart;
  logic               w_loss_inc;
  logic [3:0]         w_retry_next;
  logic               w_rx_ok;

  assign w_rx_ok = gbtrx_ready_i && !sfp_los_i;

  always_comb begin
    w_next        = r_state;
    w_fail_target = S_RX_RESET;
    w_fail        = 1'b0;
    w_restart     = 1'b0;
    w_loss_inc    = 1'b0;
    w_retry_next  = r_retry;
    if (r_state > S_FAULT) begin
      w_next = S_IDLE;
    end else if (!enable_i || (!pll_locked_i && r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else if (force_relink_i) begin
      w_next       = S_GEN_RESET;
      w_restart    = 1'b1;
      w_retry_next = 4'd0;
    end else begin
      case (r_state)
        S_IDLE:      if (pll_locked_i) w_next = S_SFP_ON;
        S_SFP_ON:    if (r_timer == T_SFP_END) w_next = S_GEN_RESET;
        S_GEN_RESET: if (r_timer == T_MGT_END) w_next = S_WAIT_TX;
        S_WAIT_TX: begin
          if (gbttx_ready_i) begin
            w_next = S_WAIT_RX;
          end else if (r_timer == T_TX_END) begin
            w_fail        = 1'b1;
            w_fail_target = S_GEN_RESET;
          end
        end
        S_WAIT_RX: begin
          if (w_rx_ok) w_next = S_STABLE;
          else if (r_timer == T_RX_END) w_fail = 1'b1;
        end
        S_RX_RESET:  if (r_timer == T_MGT_END) w_next = S_WAIT_RX;
        S_STABLE: begin
          // Any violation leaves STABLE, so the timer doubles as the clean-run count.
          if (!w_rx_ok || rx_errordetected_i) begin
            w_fail = 1'b1;
          end else if (r_timer == T_STB_END) begin
            w_next       = S_UP;
            w_retry_next = 4'd0;
          end
        end
        S_UP: begin
          if (!w_rx_ok) begin
            w_next     = S_RX_RESET;
            w_loss_inc = 1'b1;
          end
        end
        S_FAULT:     w_next = S_FAULT;
        default:     w_next = S_IDLE;
      endcase
      if (w_fail) begin
        if (r_retry >= RETRY_MAX) begin
          w_next = S_FAULT;
        end else begin
          w_next       = w_fail_target;
          w_retry_next = r_retry + 4'd1;
        end
      end
    end
    if (w_next == S_IDLE) w_retry_next = 4'd0;
  end

  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_retry     <= 4'd0;
      r_loss      <= '0;
      r_txdisable <= 1'b1;
      r_gen_reset <= 1'b1;
      r_man_tx    <= 1'b0;
      r_man_rx    <= 1'b0;
      r_link_up   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || w_restart) r_timer <= '0;
      else if (r_timer != T_SAT)          r_timer <= r_timer + TW'(1);
      r_retry <= w_retry_next;
      if (w_loss_inc && r_loss != {CNT_W{1'b1}}) r_loss <= r_loss + CNT_W'(1);
      // Outputs decode the next state so they change on the same edge as state_o.
      r_txdisable <= (w_next == S_IDLE) || (w_next == S_FAULT);
      r_gen_reset <= (w_next == S_IDLE) || (w_next == S_SFP_ON) ||
                     (w_next == S_GEN_RESET) || (w_next == S_FAULT);
      r_man_tx    <= (w_next == S_GEN_RESET);
      r_man_rx    <= (w_next == S_RX_RESET);
      r_link_up   <= (w_next == S_UP);
      r_fault     <= (w_next == S_FAULT);
    end
  end

  assign sfp_txdisable_o       = r_txdisable;
  assign gbt_general_reset_o   = r_gen_reset;
  assign gbt_manual_reset_tx_o = r_man_tx;
  assign gbt_manual_reset_rx_o = r_man_rx;
  assign link_up_o             = r_link_up;
  assign fault_o               = r_fault;
  assign state_o               = r_state;
  assign retry_cnt_o           = r_retry;
  assign link_loss_cnt_o       = r_loss;

endmodule
